// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable Moore serial-pattern detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_HIT    = 2'd2
  } state_t;

  localparam int unsigned MASK_W        = 32;
  localparam logic [3:0]  DEF_PATTERN_C = 4'b0111;
  localparam int unsigned DEF_LEN_C     = 3;

  // Mask with the low len bits set; callers truncate to their pattern width.
  function automatic logic [MASK_W-1:0] lowmask(input int unsigned len);
    if (len >= MASK_W) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seq_detect_moore_p_if.sv
// Control/data bundle between a driver and the serial-pattern detector.
interface seq_detect_moore_p_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
);
  logic             en;
  logic             w;
  logic             w_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             clr_count;
  logic             z;
  logic [CNT_W-1:0] hit_count;
  logic             armed;

  modport master (
    output en, w, w_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  z, hit_count, armed
  );

  modport slave (
    input  en, w, w_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output z, hit_count, armed
  );
endinterface

// File: rtl/seq_hist_match.sv
// Shift history and fill counter; flags a pattern match on the bit being sampled.
module seq_hist_match import seq_detect_pkg::*; #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample,
  input  logic             w,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             overlap,
  output logic             match_c
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [LEN_W-1:0] fill;
  logic [PAT_W-1:0] new_hist;
  logic [LEN_W-1:0] new_fill;
  logic [PAT_W-1:0] mask;

  assign new_hist = {hist[PAT_W-2:0], w};
  assign new_fill = (fill >= FILL_MAX) ? FILL_MAX : fill + LEN_W'(1);
  assign mask     = PAT_W'(lowmask(32'(len)));

  // Bit 0 of the pattern lines up with the newest bit of the history.
  assign match_c = sample && (len != '0) && (new_fill >= len) &&
                   (((new_hist ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (sample) begin
      hist <= new_hist;
      fill <= (match_c && !overlap) ? '0 : new_fill;
    end
  end

endmodule

// File: rtl/seq_detect_moore_p.sv
// Programmable Moore serial-pattern detector with overlap control and saturating hit counter.
module seq_detect_moore_p import seq_detect_pkg::*; #(
  parameter int unsigned      PAT_W       = 4,
  parameter int unsigned      CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PATTERN_C),
  parameter int unsigned      DEF_LEN     = DEF_LEN_C,
  parameter int unsigned      LEN_W       = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  seq_detect_moore_p_if.slave bus
);

  state_t           state;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             overlap;
  logic             z_flag;
  logic             armed_flag;
  logic [CNT_W-1:0] hits;

  logic             sample_c;
  logic             clear_c;
  logic             match_c;
  logic [LEN_W-1:0] cfg_len_clamped_c;

  // A config load in the same cycle swallows the serial bit.
  assign sample_c = bus.en && bus.w_valid && !bus.cfg_load;
  assign clear_c  = bus.cfg_load || !bus.en;
  assign cfg_len_clamped_c = (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;

  seq_hist_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_c),
    .sample  (sample_c),
    .w       (bus.w),
    .pattern (pattern),
    .len     (len),
    .overlap (overlap),
    .match_c (match_c)
  );

  // FSM and config registers; z/armed are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      z_flag     <= 1'b0;
      armed_flag <= 1'b0;
      pattern    <= DEF_PATTERN;
      len        <= LEN_W'(DEF_LEN);
      overlap    <= 1'b1;
    end else if (bus.cfg_load) begin
      pattern    <= bus.cfg_pattern;
      len        <= cfg_len_clamped_c;
      overlap    <= bus.cfg_overlap;
      state      <= bus.en ? S_SEARCH : S_IDLE;
      z_flag     <= 1'b0;
      armed_flag <= bus.en;
    end else if (!bus.en) begin
      state      <= S_IDLE;
      z_flag     <= 1'b0;
      armed_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_SEARCH, S_HIT: begin
          if (match_c) begin
            state  <= S_HIT;
            z_flag <= 1'b1;
          end else begin
            state  <= S_SEARCH;
            z_flag <= 1'b0;
          end
          armed_flag <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          z_flag     <= 1'b0;
          armed_flag <= 1'b0;
        end
      endcase
    end
  end

  // Saturating hit counter; a clear that coincides with a hit leaves one.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits <= '0;
    end else if (bus.clr_count) begin
      hits <= match_c ? CNT_W'(1) : '0;
    end else if (match_c && (hits != '1)) begin
      hits <= hits + CNT_W'(1);
    end
  end

  assign bus.z         = z_flag;
  assign bus.armed     = armed_flag;
  assign bus.hit_count = hits;

endmodule

// File: tb/tb_seq_detect_moore_p.sv
// Directed plus random bench for seq_detect_moore_p; two instances share stimulus (8-bit and 2-bit counters).
module tb_seq_detect_moore_p;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_detect_moore_p_if #(.PAT_W(4), .CNT_W(8)) bus_a ();
  seq_detect_moore_p_if #(.PAT_W(4), .CNT_W(2)) bus_b ();

  assign bus_b.en          = bus_a.en;
  assign bus_b.w           = bus_a.w;
  assign bus_b.w_valid     = bus_a.w_valid;
  assign bus_b.cfg_load    = bus_a.cfg_load;
  assign bus_b.cfg_pattern = bus_a.cfg_pattern;
  assign bus_b.cfg_len     = bus_a.cfg_len;
  assign bus_b.cfg_overlap = bus_a.cfg_overlap;
  assign bus_b.clr_count   = bus_a.clr_count;

  seq_detect_moore_p #(.PAT_W(4), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  seq_detect_moore_p #(.PAT_W(4), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  // Reference model: list of bits seen since the last clear, compared tail-first with the pattern.
  bit         q[$];
  logic [3:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         exp_z;
  bit         exp_armed;
  int         cnt_a;
  int         cnt_b;
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic bit model_hit();
    if (m_len == 0 || q.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst_i, input bit en_i, input bit wv_i, input bit w_i,
                      input bit ld_i, input logic [3:0] pat_i, input logic [2:0] len_i,
                      input bit ovl_i, input bit clr_i);
    bit hit;
    reset             = rst_i;
    bus_a.en          = en_i;
    bus_a.w_valid     = wv_i;
    bus_a.w           = w_i;
    bus_a.cfg_load    = ld_i;
    bus_a.cfg_pattern = pat_i;
    bus_a.cfg_len     = len_i;
    bus_a.cfg_overlap = ovl_i;
    bus_a.clr_count   = clr_i;
    @(posedge clk);
    hit = 1'b0;
    if (rst_i) begin
      q.delete();
      m_pat = 4'b0111; m_len = 3; m_ovl = 1'b1;
      exp_armed = 1'b0; cnt_a = 0; cnt_b = 0;
    end else begin
      if (ld_i) begin
        m_pat = pat_i; m_len = (len_i > 3'd4) ? 4 : int'(len_i); m_ovl = ovl_i;
        q.delete();
        exp_armed = en_i;
      end else if (!en_i) begin
        q.delete();
        exp_armed = 1'b0;
      end else begin
        if (wv_i) begin
          q.push_back(w_i);
          if (q.size() > 8) void'(q.pop_front());
          hit = model_hit();
          if (hit && !m_ovl) q.delete();
        end
        exp_armed = 1'b1;
      end
      if (clr_i) begin
        cnt_a = hit ? 1 : 0;
        cnt_b = hit ? 1 : 0;
      end else if (hit) begin
        if (cnt_a < 255) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
    end
    exp_z = hit;
    #1;
    check("z",       32'(bus_a.z),         32'(exp_z));
    check("armed",   32'(bus_a.armed),     32'(exp_armed));
    check("count_a", 32'(bus_a.hit_count), 32'(cnt_a));
    check("count_b", 32'(bus_b.hit_count), 32'(cnt_b));
    check("z_b",     32'(bus_b.z),         32'(exp_z));
  endtask

  task automatic bit_in(input bit w_i);
    step(1'b0, 1'b1, 1'b1, w_i, 1'b0, bus_a.cfg_pattern, bus_a.cfg_len, bus_a.cfg_overlap, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bus_a.cfg_pattern, bus_a.cfg_len, bus_a.cfg_overlap, 1'b0);
  endtask

  task automatic load(input logic [3:0] pat, input logic [2:0] len, input bit ovl, input bit clr);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pat, len, ovl, clr);
  endtask

  initial begin
    // Reset and enable
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 3'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 3'd0, 1'b1, 1'b0);
    check("reset_z", 32'(bus_a.z), 32'd0);
    check("reset_count", 32'(bus_a.hit_count), 32'd0);
    gap();
    check("armed_after_en", 32'(bus_a.armed), 32'd1);

    // 111 overlapping
    load(4'b0111, 3'd3, 1'b1, 1'b1);
    bit_in(1); bit_in(1); bit_in(1);
    check("ovl_third_z", 32'(bus_a.z), 32'd1);
    bit_in(1); bit_in(0);
    check("ovl_count", 32'(bus_a.hit_count), 32'd2);

    // 111 non-overlapping, six ones
    load(4'b0111, 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) bit_in(1);
    check("nonovl_count", 32'(bus_a.hit_count), 32'd2);

    // 101 overlapping, then with gaps
    load(4'b0101, 3'd3, 1'b1, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    check("p101_count", 32'(bus_a.hit_count), 32'd2);
    load(4'b0101, 3'd3, 1'b1, 1'b1);
    bit_in(1); gap(); bit_in(0); gap(); bit_in(1);
    check("gap_pulse", 32'(bus_a.z), 32'd1);
    gap();
    check("gap_pulse_end", 32'(bus_a.z), 32'd0);
    bit_in(0); gap(); bit_in(1); gap();
    check("gap_count", 32'(bus_a.hit_count), 32'd2);

    // Mid-stream reload discards the partial match and the coincident bit
    load(4'b0111, 3'd3, 1'b1, 1'b1);
    bit_in(1); bit_in(1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b0);
    bit_in(1);
    check("reload_no_hit", 32'(bus_a.z), 32'd0);
    bit_in(1); bit_in(1);
    check("reload_hit", 32'(bus_a.z), 32'd1);

    // Over-long length clamps to 4
    load(4'b1111, 3'd7, 1'b1, 1'b1);
    bit_in(1); bit_in(1); bit_in(1);
    check("clamp_3_bits", 32'(bus_a.z), 32'd0);
    bit_in(1);
    check("clamp_4_bits", 32'(bus_a.z), 32'd1);

    // Saturation of the 2-bit counter, then clear coinciding with a hit
    load(4'b0001, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1);
    check("sat_b", 32'(bus_b.hit_count), 32'd3);
    check("nosat_a", 32'(bus_a.hit_count), 32'd5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b1);
    check("clr_hit_b", 32'(bus_b.hit_count), 32'd1);

    // Reset mid-match restores the default pattern
    load(4'b0101, 3'd3, 1'b1, 1'b1);
    bit_in(1); bit_in(0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0101, 3'd3, 1'b1, 1'b0);
    check("rst_mid_z", 32'(bus_a.z), 32'd0);
    check("rst_mid_count", 32'(bus_a.hit_count), 32'd0);
    bit_in(1); bit_in(1); bit_in(1);
    check("default_pattern_hit", 32'(bus_a.z), 32'd1);

    // Disabled detector ignores input
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, bus_a.cfg_pattern, bus_a.cfg_len, bus_a.cfg_overlap, 1'b0);
    check("disabled_armed", 32'(bus_a.armed), 32'd0);
    bit_in(1); bit_in(1);
    check("reenable_no_hit", 32'(bus_a.z), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 250) == 0, ($urandom % 10) != 0, ($urandom % 4) != 0, 1'($urandom % 2),
           ($urandom % 40) == 0, 4'($urandom), 3'($urandom), 1'($urandom % 2),
           ($urandom % 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_moore_p.md
Name: seq_detect_moore_p

Overview:
- Parametrised Moore serial-pattern detector; successor to the fixed 6-state detector in the serial-input control path.
- Detects a runtime-programmable bit pattern of 1..PAT_W bits on a qualified serial input.
- Supports overlapping and non-overlapping match modes and keeps a saturating hit counter.
- Output z is Moore-registered: a one-cycle pulse per match.

Parameters:
- PAT_W, 4: maximum pattern length in bits (>=2).
- CNT_W, 8: hit counter width.
- DEF_PATTERN, 4'b0111 (PAT_W bits): pattern after reset.
- DEF_LEN, 3: pattern length after reset.
- LEN_W, $clog2(PAT_W+1): derived width of the length field; not overridden.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  detector enable.
- w  in  1  serial data bit.
- w_valid  in  1  w is sampled this cycle.
- cfg_load  in  1  latch cfg_pattern, cfg_len and cfg_overlap.
- cfg_pattern  in  PAT_W  bit 0 = most recent bit; bit len-1 = oldest.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- clr_count  in  1  clear the hit counter.
- z  out  1  Moore match output; high exactly while in S_HIT.
- hit_count  out  CNT_W  saturating match count.
- armed  out  1  high in S_SEARCH or S_HIT.

Behaviour:
- Reset (synchronous, active-high):
  - state = S_IDLE; z = 0; hit_count = 0; armed = 0; hist = 0; fill = 0.
  - pattern = DEF_PATTERN; len = DEF_LEN; overlap = 1.
  - Reset wins over every other input.
- States (enum):
  - S_IDLE: z = 0, armed = 0.
  - S_SEARCH: z = 0, armed = 1.
  - S_HIT: z = 1, armed = 1.
- en = 0: next state S_IDLE; hist and fill cleared; w ignored. en rising: S_IDLE -> S_SEARCH next cycle.
- cfg_load = 1 (any state, en don't-care):
  - Latch the cfg_* fields.
  - cfg_len = 0 stored as 0: never matches.
  - cfg_len > PAT_W clamped to PAT_W.
  - hist and fill cleared; if en = 1, state goes to S_SEARCH.
  - Any w_valid bit in the same cycle is discarded; cfg_load has priority.
- Sample (en = 1, w_valid = 1, no cfg_load):
  - new_hist = {hist[PAT_W-2:0], w}.
  - new_fill = min(fill+1, PAT_W).
  - match = (len != 0) && (new_fill >= len) && (((new_hist ^ pattern) & lowmask(len)) == 0).
  - hist <= new_hist.
  - fill <= (match && !overlap) ? 0 : new_fill.
  - state <= match ? S_HIT : S_SEARCH.
- No sample (en = 1, w_valid = 0): S_HIT -> S_SEARCH; hist and fill held. z is therefore a single-cycle pulse per match.
- Latency: z is high in the cycle after the edge that samples the final pattern bit. Back-to-back matches give a continuous z high, one cycle per match.
- Hit counter:
  - Increments on the same edge that enters S_HIT from a match.
  - Saturates at 2^CNT_W-1.
  - clr_count zeroes it. If clr_count coincides with a match, result = 1.
  - cfg_load and en do not affect it.
- No X states: the default branch returns to S_IDLE.

Decomposition:
- Package seq_detect_pkg:
  - state enum {S_IDLE, S_SEARCH, S_HIT}.
  - function lowmask(len), returning a PAT_W-bit mask.
  - Default pattern and length constants.
- One natural sub-module: seq_hist_match. It holds the shift history and fill counter and produces match combinationally. The top keeps the FSM, config registers and counter.

Test Plan:
- Pattern 3'b111, len 3, overlap: stream 1,1,1,1,0 with w_valid every cycle -> z high in the cycles after the 3rd and 4th bits; hit_count = 2.
- Same pattern, non-overlap (cfg_overlap = 0): six consecutive 1s -> z pulses after bits 3 and 6 only; hit_count = 2.
- Pattern 3'b101, len 3, overlap: stream 1,0,1,0,1 -> 2 pulses, after bits 3 and 5. Insert w_valid = 0 gaps between bits -> same two pulses, each one cycle, and no match lost.
- cfg_load mid-stream after 1,1 (pattern 111): partial match cleared, so a following 1 gives no pulse. cfg_load with w_valid = 1 -> bit discarded; cfg_len = 7 (PAT_W = 4) reads back behaviour for len 4.
- CNT_W = 2: five matches -> hit_count sticks at 3. clr_count together with a match -> hit_count = 1.
- Reset asserted mid-match for one cycle -> next cycle z = 0, hit_count = 0, pattern = DEF_PATTERN. en = 0 -> z = 0, armed = 0, and input is ignored until re-enabled.
